// File: rtl/mac4_pkg.sv
`default_nettype none
// ============================================================================
// mac4_pkg : shared types and constants for the 4-bit MAC stage
// Revision : 1.0
// ============================================================================
package mac4_pkg;

  localparam int P_W = 8;

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Smallest accumulator width that can hold n_terms worst-case products.
  function automatic int min_acc_w(input int n_terms);
    return $clog2(n_terms * 225 + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nhan4bitt.sv
`default_nettype none
// ============================================================================
// nhan4bitt : combinational 4x4 unsigned array multiplier
// Revision  : 1.0
// ============================================================================
module nhan4bitt
  import mac4_pkg::*;
(
  input  logic [3:0]     a,
  input  logic [3:0]     b,
  output logic [P_W-1:0] p
);

  logic [P_W-1:0] w_row [0:4];

  assign w_row[0] = '0;

  // Each row adds the shifted partial product selected by one bit of b.
  for (genvar i = 0; i < 4; i++) begin : g_row
    logic [P_W-1:0] w_pp;
    assign w_pp       = P_W'({4{b[i]}} & a) << i;
    assign w_row[i+1] = w_row[i] + w_pp;
  end

  assign p = w_row[4];

endmodule
`default_nettype wire

// File: rtl/mac4bit_acc.sv
`default_nettype none
// ============================================================================
// mac4bit_acc : accumulates N_TERMS 4x4 products, presents result on handshake
// Revision    : 1.0
// ============================================================================
module mac4bit_acc
  import mac4_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             overflow
);

  localparam int               CNT_W  = $clog2(N_TERMS + 1);
  localparam int               SUM_W  = ACC_W + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_TERMS - 1);

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic [P_W-1:0]   w_prod;
  logic [SUM_W-1:0] w_add;
  logic             w_take;
  logic             w_drain;

  nhan4bitt u_mult (
    .a (a),
    .b (b),
    .p (w_prod)
  );

  // Extra top bit of w_add is the carry out of the accumulator.
  assign w_add   = {1'b0, r_acc} + SUM_W'(w_prod);
  assign w_take  = in_valid && (r_state == ST_ACC);
  assign w_drain = out_ready && (r_state == ST_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_state <= ST_ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_take) begin
      r_acc <= w_add[ACC_W-1:0];
      r_ovf <= r_ovf | w_add[ACC_W];
      if (r_cnt == C_LAST) begin
        r_cnt   <= '0;
        r_state <= ST_HOLD;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (w_drain) begin
      r_state <= ST_ACC;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end
  end

  assign in_ready  = (r_state == ST_ACC) && !clear;
  assign out_valid = (r_state == ST_HOLD);
  assign sum       = r_acc;
  assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mac4bit_acc.sv
`default_nettype none
// ============================================================================
// tb_mac4bit_acc : directed and randomized checks for mac4bit_acc
// Revision       : 1.0
// ============================================================================
module tb_mac4bit_acc;

  logic       clk;
  logic       rst;
  logic       t_in_valid  [3];
  logic [3:0] t_a         [3];
  logic [3:0] t_b         [3];
  logic       t_clear     [3];
  logic       t_out_ready [3];
  logic       t_in_ready  [3];
  logic       t_out_valid [3];
  logic       t_overflow  [3];
  logic [11:0] sum0;
  logic [7:0]  sum1;
  logic [7:0]  sum2;
  logic [31:0] sum_w [3];

  int n_checks = 0;
  int n_fail   = 0;

  assign sum_w[0] = 32'(sum0);
  assign sum_w[1] = 32'(sum1);
  assign sum_w[2] = 32'(sum2);

  // Instance 0: defaults; 1: narrow overflow case; 2: several carries per result.
  mac4bit_acc #(.N_TERMS(4), .ACC_W(12)) dut (
    .clk(clk), .rst(rst), .in_valid(t_in_valid[0]), .in_ready(t_in_ready[0]),
    .a(t_a[0]), .b(t_b[0]), .clear(t_clear[0]), .out_valid(t_out_valid[0]),
    .out_ready(t_out_ready[0]), .sum(sum0), .overflow(t_overflow[0])
  );

  mac4bit_acc #(.N_TERMS(2), .ACC_W(8)) dut_ovf (
    .clk(clk), .rst(rst), .in_valid(t_in_valid[1]), .in_ready(t_in_ready[1]),
    .a(t_a[1]), .b(t_b[1]), .clear(t_clear[1]), .out_valid(t_out_valid[1]),
    .out_ready(t_out_ready[1]), .sum(sum1), .overflow(t_overflow[1])
  );

  mac4bit_acc #(.N_TERMS(5), .ACC_W(8)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(t_in_valid[2]), .in_ready(t_in_ready[2]),
    .a(t_a[2]), .b(t_b[2]), .clear(t_clear[2]), .out_valid(t_out_valid[2]),
    .out_ready(t_out_ready[2]), .sum(sum2), .overflow(t_overflow[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [3:0] x, input logic [3:0] y);
    t_in_valid[k] = 1'b1;
    t_a[k]        = x;
    t_b[k]        = y;
    tick();
    t_in_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    t_out_ready[k] = 1'b1;
    tick();
    t_out_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      n_checks += 4;
      if (t_in_ready[k] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, t_in_ready[k]); end
      if (t_out_valid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, t_out_valid[k]); end
      if (sum_w[k] !== 32'd0) begin n_fail++; $display("FAIL reset_sum[%0d]: got %0d want 0", k, sum_w[k]); end
      if (t_overflow[k] !== 1'b0) begin n_fail++; $display("FAIL reset_overflow[%0d]: got %b want 0", k, t_overflow[k]); end
    end
  endtask

  task automatic test_basic();
    send(0, 4'd15, 4'd10);
    send(0, 4'd15, 4'd10);
    send(0, 4'd4, 4'd10);
    n_checks++;
    if (t_out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", t_out_valid[0]); end
    send(0, 4'd1, 4'd10);
    n_checks += 4;
    if (t_out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", t_out_valid[0]); end
    if (sum_w[0] !== 32'd350) begin n_fail++; $display("FAIL basic_sum: got %0d want 350", sum_w[0]); end
    if (t_overflow[0] !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b want 0", t_overflow[0]); end
    if (t_in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready: got %b want 0", t_in_ready[0]); end
    drain(0);
    n_checks += 2;
    if (t_out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL basic_drained_valid: got %b want 0", t_out_valid[0]); end
    if (t_in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL basic_drained_ready: got %b want 1", t_in_ready[0]); end
  endtask

  task automatic test_gaps();
    send(0, 4'd15, 4'd10);
    send(0, 4'd15, 4'd10);
    repeat (3) tick();
    n_checks++;
    if (t_out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL gap_valid: got %b want 0", t_out_valid[0]); end
    send(0, 4'd4, 4'd10);
    send(0, 4'd1, 4'd10);
    n_checks += 2;
    if (t_out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL gap_result_valid: got %b want 1", t_out_valid[0]); end
    if (sum_w[0] !== 32'd350) begin n_fail++; $display("FAIL gap_sum: got %0d want 350", sum_w[0]); end
    drain(0);
    send(0, 4'd0, 4'd10);
    send(0, 4'd15, 4'd0);
    send(0, 4'd0, 4'd0);
    send(0, 4'd1, 4'd1);
    n_checks += 2;
    if (t_out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL zeros_valid: got %b want 1", t_out_valid[0]); end
    if (sum_w[0] !== 32'd1) begin n_fail++; $display("FAIL zeros_sum: got %0d want 1", sum_w[0]); end
    drain(0);
  endtask

  task automatic test_backpressure();
    send(0, 4'd15, 4'd10);
    send(0, 4'd15, 4'd10);
    send(0, 4'd4, 4'd10);
    send(0, 4'd1, 4'd10);
    t_in_valid[0] = 1'b1;
    t_a[0] = 4'd7;
    t_b[0] = 4'd7;
    for (int i = 0; i < 5; i++) begin
      n_checks += 3;
      if (t_out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, t_out_valid[0]); end
      if (sum_w[0] !== 32'd350) begin n_fail++; $display("FAIL bp_sum[%0d]: got %0d want 350", i, sum_w[0]); end
      if (t_in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, t_in_ready[0]); end
      tick();
    end
    t_in_valid[0] = 1'b0;
    drain(0);
    n_checks += 2;
    if (t_in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", t_in_ready[0]); end
    if (t_out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", t_out_valid[0]); end
    repeat (4) send(0, 4'd2, 4'd3);
    n_checks++;
    if (sum_w[0] !== 32'd24) begin n_fail++; $display("FAIL bp_next_sum: got %0d want 24", sum_w[0]); end
    drain(0);
  endtask

  task automatic test_overflow();
    send(1, 4'd15, 4'd15);
    send(1, 4'd15, 4'd15);
    n_checks += 3;
    if (t_out_valid[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b want 1", t_out_valid[1]); end
    if (sum_w[1] !== 32'd194) begin n_fail++; $display("FAIL ovf_sum: got %0d want 194", sum_w[1]); end
    if (t_overflow[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", t_overflow[1]); end
    drain(1);
    send(1, 4'd1, 4'd1);
    send(1, 4'd1, 4'd1);
    n_checks += 2;
    if (sum_w[1] !== 32'd2) begin n_fail++; $display("FAIL ovf_next_sum: got %0d want 2", sum_w[1]); end
    if (t_overflow[1] !== 1'b0) begin n_fail++; $display("FAIL ovf_next_flag: got %b want 0", t_overflow[1]); end
    drain(1);
  endtask

  task automatic test_clear();
    send(0, 4'd15, 4'd10);
    send(0, 4'd15, 4'd10);
    t_clear[0]    = 1'b1;
    t_in_valid[0] = 1'b1;
    t_a[0] = 4'd9;
    t_b[0] = 4'd9;
    #1;
    n_checks++;
    if (t_in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL clear_in_ready: got %b want 0", t_in_ready[0]); end
    tick();
    t_clear[0]    = 1'b0;
    t_in_valid[0] = 1'b0;
    n_checks++;
    if (sum_w[0] !== 32'd0) begin n_fail++; $display("FAIL clear_sum: got %0d want 0", sum_w[0]); end
    repeat (4) send(0, 4'd2, 4'd3);
    n_checks += 2;
    if (t_out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL clear_result_valid: got %b want 1", t_out_valid[0]); end
    if (sum_w[0] !== 32'd24) begin n_fail++; $display("FAIL clear_result_sum: got %0d want 24", sum_w[0]); end
    t_clear[0]     = 1'b1;
    t_out_ready[0] = 1'b1;
    tick();
    t_clear[0]     = 1'b0;
    t_out_ready[0] = 1'b0;
    n_checks += 2;
    if (t_out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL clear_hold_valid: got %b want 0", t_out_valid[0]); end
    if (sum_w[0] !== 32'd0) begin n_fail++; $display("FAIL clear_hold_sum: got %0d want 0", sum_w[0]); end
  endtask

  task automatic test_rst();
    send(0, 4'd15, 4'd10);
    send(0, 4'd15, 4'd10);
    rst = 1'b1;
    #1;
    n_checks += 3;
    if (sum_w[0] !== 32'd0) begin n_fail++; $display("FAIL rst_sum: got %0d want 0", sum_w[0]); end
    if (t_in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", t_in_ready[0]); end
    if (t_out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", t_out_valid[0]); end
    #1;
    rst = 1'b0;
    tick();
    repeat (4) send(0, 4'd2, 4'd3);
    n_checks += 2;
    if (t_out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL rst_result_valid: got %b want 1", t_out_valid[0]); end
    if (sum_w[0] !== 32'd24) begin n_fail++; $display("FAIL rst_result_sum: got %0d want 24", sum_w[0]); end
    drain(0);
  endtask

  // Reference: a result is the plain integer sum of its products; the block
  // reports it modulo 2^ACC_W and flags overflow when that sum exceeds the range.
  task automatic test_random(input int k, input int n_terms, input int acc_w);
    int  mask     = (1 << acc_w) - 1;
    bit  hold     = 1'b0;
    int  terms    = 0;
    int  total    = 0;
    int  accepted = 0;
    int  cycles   = 0;
    logic iv;
    logic ov;
    while (accepted < 1000 && cycles < 20000) begin
      iv = ($urandom_range(0, 3) != 0);
      ov = ($urandom_range(0, 1) != 0);
      t_in_valid[k]  = iv;
      t_out_ready[k] = ov;
      t_a[k] = 4'($urandom);
      t_b[k] = 4'($urandom);
      #1;
      n_checks += 2;
      if (t_in_ready[k] !== !hold) begin n_fail++; $display("FAIL rand%0d_in_ready cyc %0d: got %b want %b", k, cycles, t_in_ready[k], !hold); end
      if (t_out_valid[k] !== hold) begin n_fail++; $display("FAIL rand%0d_out_valid cyc %0d: got %b want %b", k, cycles, t_out_valid[k], hold); end
      if (hold) begin
        n_checks += 2;
        if (sum_w[k] !== 32'(total & mask)) begin n_fail++; $display("FAIL rand%0d_sum cyc %0d: got %0d want %0d", k, cycles, sum_w[k], total & mask); end
        if (t_overflow[k] !== (total > mask)) begin n_fail++; $display("FAIL rand%0d_overflow cyc %0d: got %b want %b", k, cycles, t_overflow[k], total > mask); end
      end
      if (!hold && iv) begin
        total += int'(t_a[k]) * int'(t_b[k]);
        terms++;
        accepted++;
        if (terms == n_terms) begin
          hold  = 1'b1;
          terms = 0;
        end
      end else if (hold && ov) begin
        hold  = 1'b0;
        total = 0;
      end
      tick();
      cycles++;
    end
    n_checks++;
    if (accepted < 1000) begin n_fail++; $display("FAIL rand%0d_timeout: got %0d pairs want 1000", k, accepted); end
    t_in_valid[k]  = 1'b0;
    t_out_ready[k] = 1'b0;
    t_clear[k]     = 1'b1;
    tick();
    t_clear[k]     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t_in_valid[k]  = 1'b0;
      t_a[k]         = 4'd0;
      t_b[k]         = 4'd0;
      t_clear[k]     = 1'b0;
      t_out_ready[k] = 1'b0;
    end
    #2;
    test_reset();
    tick();
    rst = 1'b0;
    tick();
    test_basic();
    test_gaps();
    test_backpressure();
    test_overflow();
    test_clear();
    test_rst();
    test_random(0, 4, 12);
    test_random(2, 5, 8);
    test_random(1, 2, 8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
